// File: rtl/sms4_key_expand.sv
// SMS4 byte S-box (combinational lookup) and the iterative SMS4 key-schedule engine.
// The engine emits the round keys rk0..rk31 one at a time over a valid/ready handshake.

module sms4_sbox (
  input  logic [7:0] x,
  output logic [7:0] s
);
  // Entry 0 sits at the left end of the constant, so byte x is found at bit offset 8*x.
  localparam logic [0:2047] TABLE = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  assign s = TABLE[{x, 3'b000} +: 8];
endmodule

module sms4_key_expand #(
  parameter int BWIDTH  = 32,
  parameter int ROT_A   = 13,
  parameter int ROT_B   = 23,
  parameter int NROUNDS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*BWIDTH-1:0]   mk,
  output logic                  busy,
  output logic [BWIDTH-1:0]     rk,
  output logic [4:0]            rk_idx,
  output logic                  rk_valid,
  input  logic                  rk_ready,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, GEN, HOLD} state_t;

  localparam logic [127:0] FK   = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;
  localparam logic [4:0]   LAST = 5'(NROUNDS - 1);

  state_t            state, state_nx;
  logic [BWIDTH-1:0] k0, k1, k2, k3;
  logic [4:0]        cnt;
  logic [BWIDTH-1:0] ck, tin, tau_out, rk_nx;
  logic              accept, gen_step, ack, last;

  function automatic logic [BWIDTH-1:0] rol(input logic [BWIDTH-1:0] v, input int n);
    return (v << n) | (v >> (BWIDTH - n));
  endfunction

  // CK byte j of round cnt is 7*(4*cnt+j) mod 256; 8-bit arithmetic gives the wrap for free.
  always_comb begin
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck[BWIDTH-1-8*j -: 8] = ({1'b0, cnt, 2'b00} + 8'(j)) * 8'd7;
    end
  end

  assign tin = k1 ^ k2 ^ k3 ^ ck;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sms4_sbox u_sbox (
      .x (tin[8*g +: 8]),
      .s (tau_out[8*g +: 8])
    );
  end

  assign rk_nx = k0 ^ tau_out ^ rol(tau_out, ROT_A) ^ rol(tau_out, ROT_B);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and datapath strobes; a start during the done cycle is held off until the next IDLE cycle.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    gen_step = 1'b0;
    ack      = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !done) begin
          accept   = 1'b1;
          state_nx = GEN;
        end
      end
      GEN: begin
        gen_step = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (rk_ready) begin
          ack      = 1'b1;
          last     = (rk_idx == LAST);
          state_nx = last ? IDLE : GEN;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Key words, round counter and the output handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      k0       <= '0;
      k1       <= '0;
      k2       <= '0;
      k3       <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      rk       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        k0   <= mk[127:96] ^ FK[127:96];
        k1   <= mk[95:64]  ^ FK[95:64];
        k2   <= mk[63:32]  ^ FK[63:32];
        k3   <= mk[31:0]   ^ FK[31:0];
        cnt  <= '0;
        busy <= 1'b1;
      end
      if (gen_step) begin
        rk       <= rk_nx;
        rk_idx   <= cnt;
        rk_valid <= 1'b1;
        k0       <= k1;
        k1       <= k2;
        k2       <= k3;
        k3       <= rk_nx;
      end
      if (ack) begin
        rk_valid <= 1'b0;
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt <= cnt + 5'd1;
        end
      end
    end
  end
endmodule
